dmem_responder: RTL and testbench

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_responder_if.sv | 22 ++
 rtl/dmem_responder.sv | 153 +++++++++++++++
 tb/tb_dmem_responder.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_responder_if.sv
// Core MEM-stage data-memory bus: request/store signals from the core,
// formatted load data, stall and error pulse back from the responder.
interface dmem_responder_if;
    logic [31:0] mem_addr_mem;
    logic [31:0] mem_wdata_mem;
    logic        mem_write_mem;
    logic        mem_read_mem;
    logic [2:0]  mem_op_mem;
    logic [31:0] mem_rdata_mem;
    logic        stall_pipl;
    logic        access_err;

    modport master (
        output mem_addr_mem, mem_wdata_mem, mem_write_mem, mem_read_mem, mem_op_mem,
        input  mem_rdata_mem, stall_pipl, access_err
    );

    modport slave (
        input  mem_addr_mem, mem_wdata_mem, mem_write_mem, mem_read_mem, mem_op_mem,
        output mem_rdata_mem, stall_pipl, access_err
    );
endinterface

// File: rtl/dmem_responder.sv
// Wait-state data memory for a RISC-V MEM stage: byte/half/word loads and stores,
// range/alignment/opcode checking, pipeline stall for the duration of each access.
module dmem_responder #(
    parameter int          DEPTH       = 1024,
    parameter int          WAIT_STATES = 1,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input logic             clk,
    input logic             reset,
    dmem_responder_if.slave bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // The IDLE cycle already counts as one stall cycle, so WAIT runs WAIT_STATES
    // cycles; the FSM always visits WAIT at least once, so 0 behaves like 1.
    localparam logic [3:0] CNT_LOAD = (WAIT_STATES > 1) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic [31:0] mem_q [DEPTH];
    logic [31:0] ram_word_q;

    logic        req, stall, do_access, mem_we;
    logic [29:0] word_off;
    logic [AW-1:0] idx;
    logic        out_of_range, misaligned, illegal, bad;
    logic [3:0]  be;
    logic [31:0] wlanes;
    logic [7:0]  word_lane [4];
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [31:0] load_data;

    assign req          = bus.mem_read_mem | bus.mem_write_mem;
    assign word_off     = bus.mem_addr_mem[31:2] - BASE_ADDR[31:2];
    assign idx          = word_off[AW-1:0];
    assign out_of_range = (bus.mem_addr_mem < BASE_ADDR) || ({2'b00, word_off} >= 32'(DEPTH));

    always_comb begin
        misaligned = 1'b0;
        case (bus.mem_op_mem[1:0])
            2'b01:   misaligned = bus.mem_addr_mem[0];
            2'b10:   misaligned = |bus.mem_addr_mem[1:0];
            default: misaligned = 1'b0;
        endcase
    end

    // A simultaneous read+write is treated as a store, so store rules apply.
    always_comb begin
        if (bus.mem_write_mem)
            illegal = !(bus.mem_op_mem inside {3'b000, 3'b001, 3'b010});
        else
            illegal = bus.mem_op_mem inside {3'b011, 3'b110, 3'b111};
    end

    assign bad    = out_of_range | misaligned | illegal;
    assign mem_we = do_access & bus.mem_write_mem & ~bad & ~reset;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign word_lane[gi] = ram_word_q[gi*8 +: 8];
            assign wlanes[gi*8 +: 8] =
                (bus.mem_op_mem[1:0] == 2'b00) ? bus.mem_wdata_mem[7:0] :
                (bus.mem_op_mem[1:0] == 2'b01) ? bus.mem_wdata_mem[(gi%2)*8 +: 8] :
                                                 bus.mem_wdata_mem[gi*8 +: 8];
            assign be[gi] =
                (bus.mem_op_mem[1:0] == 2'b00) ? (bus.mem_addr_mem[1:0] == 2'(gi)) :
                (bus.mem_op_mem[1:0] == 2'b01) ? (bus.mem_addr_mem[1] == 1'(gi / 2)) :
                                                 1'b1;
        end
    endgenerate

    assign rd_byte = word_lane[bus.mem_addr_mem[1:0]];
    assign rd_half = bus.mem_addr_mem[1] ? ram_word_q[31:16] : ram_word_q[15:0];

    always_comb begin
        load_data = '0;
        case (bus.mem_op_mem)
            3'b000:  load_data = {{24{rd_byte[7]}}, rd_byte};
            3'b100:  load_data = {24'd0, rd_byte};
            3'b001:  load_data = {{16{rd_half[15]}}, rd_half};
            3'b101:  load_data = {16'd0, rd_half};
            3'b010:  load_data = ram_word_q;
            default: load_data = '0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        stall     = 1'b0;
        do_access = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req && !reset) begin
                    stall   = 1'b1;
                    cnt_d   = CNT_LOAD;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                stall = 1'b1;
                if (!req) begin
                    state_d = S_IDLE;
                end else if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    do_access = 1'b1;
                    err_d     = bad;
                    rdata_d   = (bad || bus.mem_write_mem) ? 32'd0 : load_data;
                    state_d   = S_RESP;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Address is held from the IDLE cycle on, so the word read here is ready
    // by the access edge; storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        ram_word_q <= mem_q[idx];
        if (mem_we) begin
            for (int l = 0; l < 4; l++) begin
                if (be[l]) mem_q[idx][l*8 +: 8] <= wlanes[l*8 +: 8];
            end
        end
    end

    assign bus.stall_pipl    = stall;
    assign bus.mem_rdata_mem = (state_q == S_RESP) ? rdata_q : 32'd0;
    assign bus.access_err    = (state_q == S_RESP) & err_q;
endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench: stimulus pushes the expected response of every request, a
// monitor pops one entry each time a stall window closes and compares it.
module tb_dmem_responder;
    localparam logic [2:0] B = 3'b000, H = 3'b001, W = 3'b010, BU = 3'b100, HU = 3'b101;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          len;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset0, reset1;
    logic [31:0] addr_r [2];
    logic [31:0] wdata_r [2];
    logic        wr_r [2];
    logic        rd_r [2];
    logic [2:0]  op_r [2];
    logic        stall_w [2];
    logic [31:0] rdata_w [2];
    logic        err_w [2];

    dmem_responder_if bus0 ();
    dmem_responder_if bus1 ();

    assign bus0.mem_addr_mem  = addr_r[0];
    assign bus0.mem_wdata_mem = wdata_r[0];
    assign bus0.mem_write_mem = wr_r[0];
    assign bus0.mem_read_mem  = rd_r[0];
    assign bus0.mem_op_mem    = op_r[0];
    assign bus1.mem_addr_mem  = addr_r[1];
    assign bus1.mem_wdata_mem = wdata_r[1];
    assign bus1.mem_write_mem = wr_r[1];
    assign bus1.mem_read_mem  = rd_r[1];
    assign bus1.mem_op_mem    = op_r[1];
    assign stall_w[0] = bus0.stall_pipl;
    assign rdata_w[0] = bus0.mem_rdata_mem;
    assign err_w[0]   = bus0.access_err;
    assign stall_w[1] = bus1.stall_pipl;
    assign rdata_w[1] = bus1.mem_rdata_mem;
    assign err_w[1]   = bus1.access_err;

    dmem_responder #(.DEPTH(64), .WAIT_STATES(1), .BASE_ADDR(32'h0000_0000)) u_dut0 (
        .clk   (clk),
        .reset (reset0),
        .bus   (bus0.slave)
    );

    dmem_responder #(.DEPTH(16), .WAIT_STATES(3), .BASE_ADDR(32'h0000_1000)) u_dut1 (
        .clk   (clk),
        .reset (reset1),
        .bus   (bus1.slave)
    );

    int   n_checks = 0;
    int   n_errs   = 0;
    bit   mon_en   = 1'b0;
    exp_t exp_q0 [$];
    exp_t exp_q1 [$];
    int   run_len [2];
    logic [5:0] pat;

    function automatic void chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errs++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endfunction

    function automatic void push_exp(input int d, input logic [31:0] rd, input logic e, input int len);
        exp_t x;
        x.rdata = rd;
        x.err   = e;
        x.len   = len;
        if (d == 0) exp_q0.push_back(x);
        else        exp_q1.push_back(x);
    endfunction

    // Monitor: while stalled the outputs must be idle; the first non-stall
    // cycle after a window is the response (or abort/reset) cycle.
    always @(negedge clk) begin
        if (mon_en) begin
            for (int d = 0; d < 2; d++) begin
                if (stall_w[d]) begin
                    run_len[d]++;
                    chk($sformatf("dut%0d_rdata_during_stall", d), rdata_w[d], 32'd0);
                    chk($sformatf("dut%0d_err_during_stall", d), {31'd0, err_w[d]}, 32'd0);
                end else if (run_len[d] != 0) begin
                    exp_t e;
                    if ((d == 0 && exp_q0.size() == 0) || (d == 1 && exp_q1.size() == 0)) begin
                        chk($sformatf("dut%0d_unexpected_response", d), 32'd1, 32'd0);
                    end else begin
                        if (d == 0) e = exp_q0.pop_front();
                        else        e = exp_q1.pop_front();
                        $display("txn dut%0d rdata=%h err=%b stall_len=%0d", d, rdata_w[d], err_w[d], run_len[d]);
                        chk($sformatf("dut%0d_rdata", d), rdata_w[d], e.rdata);
                        chk($sformatf("dut%0d_access_err", d), {31'd0, err_w[d]}, {31'd0, e.err});
                        chk($sformatf("dut%0d_stall_len", d), 32'(run_len[d]), 32'(e.len));
                    end
                    run_len[d] = 0;
                end else begin
                    chk($sformatf("dut%0d_err_outside_resp", d), {31'd0, err_w[d]}, 32'd0);
                end
            end
        end
    end

    task automatic wait_resp(input int d);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (stall_w[d] && n < 64);
        if (stall_w[d]) chk($sformatf("dut%0d_stall_timeout", d), 32'd1, 32'd0);
    endtask

    task automatic do_req(input int d, input logic w, input logic r, input logic [2:0] op,
                          input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] er, input logic ee, input int el);
        push_exp(d, er, ee, el);
        wr_r[d] = w; rd_r[d] = r; op_r[d] = op; addr_r[d] = a; wdata_r[d] = wd;
        wait_resp(d);
        @(posedge clk); #1;
        wr_r[d] = 1'b0; rd_r[d] = 1'b0;
    endtask

    // Request is withdrawn after 'hold' edges; the stall window then closes with no response.
    task automatic do_abort(input int d, input logic w, input logic [2:0] op,
                            input logic [31:0] a, input logic [31:0] wd, input int hold);
        push_exp(d, 32'd0, 1'b0, hold + 1);
        wr_r[d] = w; rd_r[d] = !w; op_r[d] = op; addr_r[d] = a; wdata_r[d] = wd;
        repeat (hold) @(posedge clk);
        #1;
        wr_r[d] = 1'b0; rd_r[d] = 1'b0;
        wait_resp(d);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        for (int d = 0; d < 2; d++) begin
            addr_r[d] = 32'd0; wdata_r[d] = 32'd0; wr_r[d] = 1'b0; rd_r[d] = 1'b0; op_r[d] = W;
            run_len[d] = 0;
        end
        reset0 = 1'b1; reset1 = 1'b1;
        rd_r[0] = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("stall_ignored_during_reset", {31'd0, stall_w[0]}, 32'd0);
        rd_r[0] = 1'b0;
        @(posedge clk); #1;
        reset0 = 1'b0; reset1 = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("dut%0d_reset_stall", d), {31'd0, stall_w[d]}, 32'd0);
            chk($sformatf("dut%0d_reset_rdata", d), rdata_w[d], 32'd0);
            chk($sformatf("dut%0d_reset_err", d), {31'd0, err_w[d]}, 32'd0);
        end
        mon_en = 1'b1;
        @(posedge clk); #1;

        // dut0: WAIT_STATES=1, BASE 0, 64 words
        do_req(0, 1, 0, W,  32'h10, 32'hDEADBEEF, 32'h0,        0, 2);
        do_req(0, 0, 1, W,  32'h10, 32'h0,        32'hDEADBEEF, 0, 2);
        do_req(0, 1, 0, B,  32'h13, 32'hCAFE0080, 32'h0,        0, 2);
        do_req(0, 0, 1, B,  32'h13, 32'h0,        32'hFFFFFF80, 0, 2);
        do_req(0, 0, 1, BU, 32'h13, 32'h0,        32'h00000080, 0, 2);
        do_req(0, 0, 1, W,  32'h10, 32'h0,        32'h80ADBEEF, 0, 2);
        do_req(0, 1, 0, H,  32'h12, 32'hABCD1234, 32'h0,        0, 2);
        do_req(0, 0, 1, H,  32'h12, 32'h0,        32'h00001234, 0, 2);
        do_req(0, 0, 1, H,  32'h11, 32'h0,        32'h0,        1, 2);
        do_req(0, 0, 1, W,  32'h10, 32'h0,        32'h1234BEEF, 0, 2);
        do_req(0, 0, 1, B,  32'h11, 32'h0,        32'hFFFFFFBE, 0, 2);
        do_req(0, 0, 1, BU, 32'h10, 32'h0,        32'h000000EF, 0, 2);
        do_req(0, 0, 1, HU, 32'h10, 32'h0,        32'h0000BEEF, 0, 2);
        do_req(0, 0, 1, H,  32'h10, 32'h0,        32'hFFFFBEEF, 0, 2);
        do_req(0, 1, 0, W,  32'h00, 32'h01020304, 32'h0,        0, 2);
        do_req(0, 1, 0, W,  32'h100, 32'hFFFFFFFF, 32'h0,       1, 2);
        do_req(0, 0, 1, W,  32'h00, 32'h0,        32'h01020304, 0, 2);
        do_req(0, 0, 1, 3'b011, 32'h10, 32'h0,    32'h0,        1, 2);
        do_req(0, 1, 0, BU, 32'h12, 32'h000000FF, 32'h0,        1, 2);
        do_req(0, 0, 1, W,  32'h10, 32'h0,        32'h1234BEEF, 0, 2);
        do_req(0, 1, 1, W,  32'h14, 32'h0BADF00D, 32'h0,        0, 2);
        do_req(0, 0, 1, W,  32'h14, 32'h0,        32'h0BADF00D, 0, 2);
        do_req(0, 1, 0, W,  32'h20, 32'h11111111, 32'h0,        0, 2);
        do_abort(0, 1, W, 32'h20, 32'h22222222, 1);
        do_req(0, 1, 0, W,  32'h22, 32'h33333333, 32'h0,        1, 2);
        do_req(0, 0, 1, W,  32'h20, 32'h0,        32'h11111111, 0, 2);
        fork
            begin
                do_req(0, 0, 1, W, 32'h10, 32'h0, 32'h1234BEEF, 0, 2);
                do_req(0, 0, 1, W, 32'h14, 32'h0, 32'h0BADF00D, 0, 2);
            end
            begin
                pat = 6'd0;
                for (int i = 0; i < 6; i++) begin
                    @(negedge clk);
                    pat = {pat[4:0], stall_w[0]};
                end
                chk("back_to_back_stall_pattern", {26'd0, pat}, 32'b110110);
            end
        join

        // dut1: WAIT_STATES=3, BASE 0x1000, 16 words
        do_req(1, 1, 0, W, 32'h1008, 32'hAAAA5555, 32'h0, 0, 4);
        push_exp(1, 32'h0, 1'b0, 3);
        wr_r[1] = 1'b1; rd_r[1] = 1'b0; op_r[1] = W; addr_r[1] = 32'h1008; wdata_r[1] = 32'h12345678;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset1 = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset1 = 1'b0;
        wr_r[1] = 1'b0;
        @(posedge clk); #1;
        do_req(1, 0, 1, W,  32'h1008, 32'h0, 32'hAAAA5555, 0, 4);
        do_req(1, 0, 1, W,  32'h0FFC, 32'h0, 32'h0,        1, 4);
        do_req(1, 0, 1, W,  32'h1040, 32'h0, 32'h0,        1, 4);
        do_abort(1, 0, W, 32'h1008, 32'h0, 2);
        do_req(1, 0, 1, HU, 32'h100A, 32'h0, 32'h0000AAAA, 0, 4);

        repeat (3) @(posedge clk);
        chk("dut0_scoreboard_drained", 32'(exp_q0.size()), 32'd0);
        chk("dut1_scoreboard_drained", 32'(exp_q1.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end
endmodule
